// File: rtl/axis_hdr_pkg.sv
// Shared types and default widths for the header-insertion arbiter slice.
// The state enum is used by the top FSM; the defaults size its parameters.
package axis_hdr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        BODY = 2'd2
    } state_e;

    localparam int DEF_DATA_WD = 32;
    localparam int DEF_NUM_SRC = 4;

endpackage

// File: rtl/axis_insert_header_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the request vector is rotated so the search
// starts just above the previous grantee, then priority-encoded.
module rr_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int SRC_WD  = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_WD-1:0]  last_grant,
    output logic [NUM_SRC-1:0] gnt,
    output logic [SRC_WD-1:0]  gnt_idx,
    output logic               any
);

    localparam logic [SRC_WD:0] NUM_SRC_W = (SRC_WD + 1)'(NUM_SRC);

    logic [SRC_WD:0]        inc_s;
    logic [SRC_WD:0]        start_s;
    logic [SRC_WD:0]        found_s;
    logic [SRC_WD:0]        sum_s;
    logic [SRC_WD:0]        wrap_s;
    logic [2*NUM_SRC-1:0]   dbl_s;
    logic [NUM_SRC-1:0]     rot_s;

    // Rotate-and-encode; the one-extra-bit sums absorb the modulo wrap
    always_comb begin
        inc_s   = {1'b0, last_grant} + (SRC_WD + 1)'(1);
        start_s = (inc_s >= NUM_SRC_W) ? (SRC_WD + 1)'(0) : inc_s;
        dbl_s   = {req, req} >> start_s;
        rot_s   = dbl_s[NUM_SRC-1:0];
        found_s = (SRC_WD + 1)'(0);
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            found_s = rot_s[i] ? (SRC_WD + 1)'(i) : found_s;
        end
        sum_s   = start_s + found_s;
        wrap_s  = (sum_s >= NUM_SRC_W) ? (sum_s - NUM_SRC_W) : sum_s;
        gnt_idx = SRC_WD'(wrap_s);
        any     = |req;
        gnt     = any ? (NUM_SRC'(1) << gnt_idx) : NUM_SRC'(0);
    end

endmodule

// File: rtl/axis_insert_header_arbiter.sv
// Shares one header-insertion datapath between NUM_SRC requesters: each grant
// forwards the winner's header, then its body, until the last beat is taken.
module axis_insert_header_arbiter
    import axis_hdr_pkg::*;
#(
    parameter int DATA_WD      = DEF_DATA_WD,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
    parameter int NUM_SRC      = DEF_NUM_SRC,
    parameter int SRC_WD       = $clog2(NUM_SRC)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_SRC-1:0]                s_valid_insert,
    output logic [NUM_SRC-1:0]                s_ready_insert,
    input  logic [NUM_SRC*DATA_WD-1:0]        s_data_insert,
    input  logic [NUM_SRC*DATA_BYTE_WD-1:0]   s_keep_insert,
    input  logic [NUM_SRC*BYTE_CNT_WD-1:0]    s_byte_insert_cnt,
    input  logic [NUM_SRC-1:0]                s_valid_in,
    input  logic [NUM_SRC-1:0]                s_last_in,
    output logic [NUM_SRC-1:0]                s_ready_in,
    input  logic [NUM_SRC*DATA_WD-1:0]        s_data_in,
    input  logic [NUM_SRC*DATA_BYTE_WD-1:0]   s_keep_in,
    output logic                              m_valid_insert,
    input  logic                              m_ready_insert,
    output logic [DATA_WD-1:0]                m_data_insert,
    output logic [DATA_BYTE_WD-1:0]           m_keep_insert,
    output logic [BYTE_CNT_WD-1:0]            m_byte_insert_cnt,
    output logic                              m_valid_in,
    input  logic                              m_ready_in,
    output logic [DATA_WD-1:0]                m_data_in,
    output logic [DATA_BYTE_WD-1:0]           m_keep_in,
    output logic                              m_last_in,
    output logic [SRC_WD-1:0]                 grant_id,
    output logic                              busy
);

    state_e               state_q, state_d;
    logic [SRC_WD-1:0]    grant_id_q, grant_id_d;
    logic [SRC_WD-1:0]    last_grant_q, last_grant_d;
    logic [NUM_SRC-1:0]   grant_oh_q, grant_oh_d;
    logic [NUM_SRC-1:0]   arb_gnt_s;
    logic [SRC_WD-1:0]    arb_idx_s;
    logic                 arb_any_s;
    int                   sel_s;

    rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .SRC_WD  (SRC_WD)
    ) u_rr_arbiter (
        .req        (s_valid_insert),
        .last_grant (last_grant_q),
        .gnt        (arb_gnt_s),
        .gnt_idx    (arb_idx_s),
        .any        (arb_any_s)
    );

    // State and grant registers; async reset abandons any packet in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_id_q   <= SRC_WD'(0);
            last_grant_q <= SRC_WD'(NUM_SRC - 1);
            grant_oh_q   <= NUM_SRC'(0);
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            grant_oh_q   <= grant_oh_d;
        end
    end

    // Next-state: arbitrate only in IDLE, then hold the grant through the last body beat
    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        grant_oh_d   = grant_oh_q;
        case (state_q)
            IDLE: begin
                if (arb_any_s) begin
                    state_d      = HDR;
                    grant_id_d   = arb_idx_s;
                    last_grant_d = arb_idx_s;
                    grant_oh_d   = arb_gnt_s;
                end else begin
                    state_d = IDLE;
                end
            end
            HDR: begin
                if (m_valid_insert && m_ready_insert) begin
                    state_d = BODY;
                end else begin
                    state_d = HDR;
                end
            end
            BODY: begin
                if (m_valid_in && m_ready_in && m_last_in) begin
                    state_d = IDLE;
                end else begin
                    state_d = BODY;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Slice muxes: payloads follow grant_id, valids and readies are gated by state
    always_comb begin
        sel_s             = int'(grant_id_q);
        m_data_insert     = s_data_insert[sel_s*DATA_WD +: DATA_WD];
        m_keep_insert     = s_keep_insert[sel_s*DATA_BYTE_WD +: DATA_BYTE_WD];
        m_byte_insert_cnt = s_byte_insert_cnt[sel_s*BYTE_CNT_WD +: BYTE_CNT_WD];
        m_data_in         = s_data_in[sel_s*DATA_WD +: DATA_WD];
        m_keep_in         = s_keep_in[sel_s*DATA_BYTE_WD +: DATA_BYTE_WD];
        m_last_in         = s_last_in[grant_id_q];
        if (state_q == HDR) begin
            m_valid_insert = s_valid_insert[grant_id_q];
            s_ready_insert = grant_oh_q & {NUM_SRC{m_ready_insert}};
        end else begin
            m_valid_insert = 1'b0;
            s_ready_insert = NUM_SRC'(0);
        end
        if (state_q == BODY) begin
            m_valid_in = s_valid_in[grant_id_q];
            s_ready_in = grant_oh_q & {NUM_SRC{m_ready_in}};
        end else begin
            m_valid_in = 1'b0;
            s_ready_in = NUM_SRC'(0);
        end
    end

    assign grant_id = grant_id_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_axis_insert_header_arbiter.sv
// Directed bench for the header-insertion arbiter with hand-computed expectations.
module tb_axis_insert_header_arbiter;

    localparam int DW = 32;
    localparam int BW = 4;
    localparam int CW = 2;
    localparam int NS = 4;
    localparam int SW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NS-1:0]     s_valid_insert, s_ready_insert;
    logic [NS*DW-1:0]  s_data_insert;
    logic [NS*BW-1:0]  s_keep_insert;
    logic [NS*CW-1:0]  s_byte_insert_cnt;
    logic [NS-1:0]     s_valid_in, s_last_in, s_ready_in;
    logic [NS*DW-1:0]  s_data_in;
    logic [NS*BW-1:0]  s_keep_in;
    logic              m_valid_insert, m_ready_insert;
    logic [DW-1:0]     m_data_insert;
    logic [BW-1:0]     m_keep_insert;
    logic [CW-1:0]     m_byte_insert_cnt;
    logic              m_valid_in, m_ready_in, m_last_in;
    logic [DW-1:0]     m_data_in;
    logic [BW-1:0]     m_keep_in;
    logic [SW-1:0]     grant_id;
    logic              busy;

    int n_checks = 0;
    int n_pass   = 0;

    axis_insert_header_arbiter #(
        .DATA_WD (DW),
        .NUM_SRC (NS)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .s_valid_insert    (s_valid_insert),
        .s_ready_insert    (s_ready_insert),
        .s_data_insert     (s_data_insert),
        .s_keep_insert     (s_keep_insert),
        .s_byte_insert_cnt (s_byte_insert_cnt),
        .s_valid_in        (s_valid_in),
        .s_last_in         (s_last_in),
        .s_ready_in        (s_ready_in),
        .s_data_in         (s_data_in),
        .s_keep_in         (s_keep_in),
        .m_valid_insert    (m_valid_insert),
        .m_ready_insert    (m_ready_insert),
        .m_data_insert     (m_data_insert),
        .m_keep_insert     (m_keep_insert),
        .m_byte_insert_cnt (m_byte_insert_cnt),
        .m_valid_in        (m_valid_in),
        .m_ready_in        (m_ready_in),
        .m_data_in         (m_data_in),
        .m_keep_in         (m_keep_in),
        .m_last_in         (m_last_in),
        .grant_id          (grant_id),
        .busy              (busy)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_hdr(input int src, input logic v, input logic [31:0] d, input logic [1:0] cnt);
        s_valid_insert[src]              = v;
        s_data_insert[src*DW +: DW]      = d;
        s_keep_insert[src*BW +: BW]      = 4'hF;
        s_byte_insert_cnt[src*CW +: CW]  = cnt;
    endtask

    task automatic set_body(input int src, input logic v, input logic [31:0] d, input logic l);
        s_valid_in[src]             = v;
        s_data_in[src*DW +: DW]     = d;
        s_keep_in[src*BW +: BW]     = 4'hF;
        s_last_in[src]              = l;
    endtask

    task automatic clear_inputs();
        s_valid_insert    = '0;
        s_data_insert     = '0;
        s_keep_insert     = '0;
        s_byte_insert_cnt = '0;
        s_valid_in        = '0;
        s_last_in         = '0;
        s_data_in         = '0;
        s_keep_in         = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        clear_inputs();
        m_ready_insert = 1'b1;
        m_ready_in     = 1'b1;
        rst_n          = 1'b0;
        #1;
        // Reset state
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_grant", 32'(grant_id), 32'd0);
        check_eq("rst_mvi", 32'(m_valid_insert), 32'd0);
        check_eq("rst_mvd", 32'(m_valid_in), 32'd0);
        check_eq("rst_sri", 32'(s_ready_insert), 32'd0);
        check_eq("rst_srd", 32'(s_ready_in), 32'd0);
        do_reset();

        // Source 2 alone, 3-beat packet
        set_hdr(2, 1'b1, 32'hAABBCCDD, 2'd1);
        #1;
        check_eq("t1_idle_mvi", 32'(m_valid_insert), 32'd0);
        tick();
        set_body(2, 1'b1, 32'h11, 1'b0);
        #1;
        check_eq("t1_hdr_mvi", 32'(m_valid_insert), 32'd1);
        check_eq("t1_grant", 32'(grant_id), 32'd2);
        check_eq("t1_hdr_data", m_data_insert, 32'hAABBCCDD);
        check_eq("t1_hdr_cnt", 32'(m_byte_insert_cnt), 32'd1);
        check_eq("t1_sri", 32'(s_ready_insert), 32'b0100);
        check_eq("t1_busy", 32'(busy), 32'd1);
        check_eq("t1_body_blk", 32'(m_valid_in), 32'd0);
        check_eq("t1_srd_blk", 32'(s_ready_in), 32'd0);
        tick();
        set_hdr(2, 1'b0, 32'h0, 2'd0);
        #1;
        check_eq("t1_b0_valid", 32'(m_valid_in), 32'd1);
        check_eq("t1_b0_data", m_data_in, 32'h11);
        check_eq("t1_b0_srd", 32'(s_ready_in), 32'b0100);
        check_eq("t1_b0_sri", 32'(s_ready_insert), 32'd0);
        tick();
        set_body(2, 1'b1, 32'h22, 1'b0);
        #1;
        check_eq("t1_b1_data", m_data_in, 32'h22);
        tick();
        set_body(2, 1'b1, 32'h33, 1'b1);
        #1;
        check_eq("t1_b2_data", m_data_in, 32'h33);
        check_eq("t1_b2_last", 32'(m_last_in), 32'd1);
        tick();
        set_body(2, 1'b0, 32'h0, 1'b0);
        #1;
        check_eq("t1_end_busy", 32'(busy), 32'd0);
        check_eq("t1_end_mvd", 32'(m_valid_in), 32'd0);
        check_eq("t1_end_grant", 32'(grant_id), 32'd2);

        // All four request continuously with 1-beat packets
        do_reset();
        for (int i = 0; i < NS; i++) begin
            set_hdr(i, 1'b1, 32'hA0 + 32'(i), 2'(i));
            set_body(i, 1'b1, 32'hD0 + 32'(i), 1'b1);
        end
        tick();
        for (int k = 0; k < 5; k++) begin
            #1;
            check_eq("rr_grant", 32'(grant_id), 32'(k % NS));
            check_eq("rr_mvi", 32'(m_valid_insert), 32'd1);
            check_eq("rr_hdr", m_data_insert, 32'hA0 + 32'(k % NS));
            tick();
            #1;
            check_eq("rr_body", m_data_in, 32'hD0 + 32'(k % NS));
            check_eq("rr_last", 32'(m_last_in & m_valid_in), 32'd1);
            tick();
            #1;
            check_eq("rr_bubble", 32'(busy), 32'd0);
            if (k < 4) begin
                tick();
            end else begin
                clear_inputs();
            end
        end
        tick();

        // Grantee 1 presents body before its header is taken
        m_ready_insert = 1'b0;
        set_hdr(1, 1'b1, 32'h0101, 2'd2);
        set_body(1, 1'b1, 32'hE1, 1'b1);
        tick();
        #1;
        check_eq("t3_grant", 32'(grant_id), 32'd1);
        check_eq("t3_srd_hdr", 32'(s_ready_in), 32'd0);
        tick();
        #1;
        check_eq("t3_srd_stall", 32'(s_ready_in), 32'd0);
        m_ready_insert = 1'b1;
        #1;
        check_eq("t3_srd_hs", 32'(s_ready_in), 32'd0);
        check_eq("t3_sri_hs", 32'(s_ready_insert), 32'b0010);
        tick();
        set_hdr(1, 1'b0, 32'h0, 2'd0);
        #1;
        check_eq("t3_srd_body", 32'(s_ready_in), 32'b0010);
        check_eq("t3_data", m_data_in, 32'hE1);
        tick();
        set_body(1, 1'b0, 32'h0, 1'b0);
        #1;
        check_eq("t3_idle", 32'(busy), 32'd0);

        // Source 0 packet with a 5-cycle stall; source 3 requests meanwhile
        set_hdr(0, 1'b1, 32'h0A0A, 2'd0);
        tick();
        set_hdr(3, 1'b1, 32'h3333, 2'd3);
        set_body(0, 1'b1, 32'hB0, 1'b0);
        #1;
        check_eq("t4_grant0", 32'(grant_id), 32'd0);
        tick();
        set_hdr(0, 1'b0, 32'h0, 2'd0);
        #1;
        check_eq("t4_b0", m_data_in, 32'hB0);
        tick();
        set_body(0, 1'b1, 32'hB1, 1'b0);
        m_ready_in = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            check_eq("t4_stall_mvd", 32'(m_valid_in), 32'd1);
            check_eq("t4_stall_data", m_data_in, 32'hB1);
            check_eq("t4_stall_srd", 32'(s_ready_in), 32'd0);
            check_eq("t4_stall_sri", 32'(s_ready_insert), 32'd0);
            check_eq("t4_stall_grant", 32'(grant_id), 32'd0);
            tick();
        end
        m_ready_in = 1'b1;
        #1;
        check_eq("t4_b1", m_data_in, 32'hB1);
        check_eq("t4_srd", 32'(s_ready_in), 32'b0001);
        tick();
        set_body(0, 1'b1, 32'hB2, 1'b1);
        #1;
        check_eq("t4_b2", m_data_in, 32'hB2);
        tick();
        set_body(0, 1'b0, 32'h0, 1'b0);
        #1;
        check_eq("t4_bubble_busy", 32'(busy), 32'd0);
        check_eq("t4_bubble_mvi", 32'(m_valid_insert), 32'd0);
        tick();
        set_body(3, 1'b1, 32'hC3, 1'b1);
        #1;
        check_eq("t4_grant3", 32'(grant_id), 32'd3);
        check_eq("t4_mvi3", 32'(m_valid_insert), 32'd1);
        check_eq("t4_hdr3", m_data_insert, 32'h3333);
        tick();
        set_hdr(3, 1'b0, 32'h0, 2'd0);
        tick();
        set_body(3, 1'b0, 32'h0, 1'b0);

        // Reset mid-packet, after 2 of 4 beats of source 1
        set_hdr(1, 1'b1, 32'h1111, 2'd0);
        tick();
        set_body(1, 1'b1, 32'h51, 1'b0);
        tick();
        set_hdr(1, 1'b0, 32'h0, 2'd0);
        tick();
        set_body(1, 1'b1, 32'h52, 1'b0);
        tick();
        set_body(1, 1'b1, 32'h53, 1'b0);
        #1;
        check_eq("t5_pre_busy", 32'(busy), 32'd1);
        check_eq("t5_pre_data", m_data_in, 32'h53);
        rst_n = 1'b0;
        #1;
        check_eq("t5_rst_busy", 32'(busy), 32'd0);
        check_eq("t5_rst_mvd", 32'(m_valid_in), 32'd0);
        check_eq("t5_rst_srd", 32'(s_ready_in), 32'd0);
        check_eq("t5_rst_grant", 32'(grant_id), 32'd0);
        clear_inputs();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < NS; i++) begin
            set_hdr(i, 1'b1, 32'hF0 + 32'(i), 2'd0);
        end
        tick();
        #1;
        check_eq("t5_first_grant", 32'(grant_id), 32'd0);
        check_eq("t5_first_mvi", 32'(m_valid_insert), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axis_insert_header_arbiter.md
# axis_insert_header_arbiter

Round-robin scheduler that shares one header-insertion datapath (`axi_stream_insert_header`) between `NUM_SRC` requesters. Each requester presents a header on its insert channel and a packet on its data channel. The arbiter grants one requester at a time and routes its header, then its packet body, to the shared datapath. The grant is held until the body beat carrying last is accepted.

## Interface
- `DATA_WD`, 32, data width in bits
- `DATA_BYTE_WD`, `DATA_WD/8`, bytes per beat
- `BYTE_CNT_WD`, `$clog2(DATA_BYTE_WD)`, width of byte_insert_cnt
- `NUM_SRC`, 4, number of requesters (2..16)
- `SRC_WD`, `$clog2(NUM_SRC)`, width of grant index
- `clk` in 1: clock, rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `s_valid_insert`, `s_ready_insert` in/out `NUM_SRC`: per-source header handshake
- `s_data_insert` in `NUM_SRC*DATA_WD`; `s_keep_insert` in `NUM_SRC*DATA_BYTE_WD`; `s_byte_insert_cnt` in `NUM_SRC*BYTE_CNT_WD`: flattened headers, source i at slice i
- `s_valid_in`, `s_last_in` in `NUM_SRC`; `s_ready_in` out `NUM_SRC`: per-source body handshake
- `s_data_in` in `NUM_SRC*DATA_WD`; `s_keep_in` in `NUM_SRC*DATA_BYTE_WD`: flattened body beats
- `m_valid_insert` out 1, `m_ready_insert` in 1, `m_data_insert` out `DATA_WD`, `m_keep_insert` out `DATA_BYTE_WD`, `m_byte_insert_cnt` out `BYTE_CNT_WD`: header to the datapath
- `m_valid_in` out 1, `m_ready_in` in 1, `m_data_in` out `DATA_WD`, `m_keep_in` out `DATA_BYTE_WD`, `m_last_in` out 1: body to the datapath
- `grant_id` out `SRC_WD`: index of the current or most recent grantee
- `busy` out 1: high in HDR and BODY

## Operation
- FSM has three states: IDLE, HDR and BODY.
- **IDLE**
  - Requests are `s_valid_insert`.
  - If any request is high, the round-robin pick searches upward from `last_grant+1` (mod `NUM_SRC`) and takes the first high bit.
  - Next cycle: register `grant_id`, update `last_grant`, go to HDR.
  - No request: remain in IDLE.
- **HDR**
  - `m_*_insert` = slice `grant_id` of `s_*_insert`.
  - `s_ready_insert[grant_id]` = `m_ready_insert`.
  - On `m_valid_insert && m_ready_insert`, go to BODY.
- **BODY**
  - `m_valid_in`, `m_data_in`, `m_keep_in`, `m_last_in` = slice `grant_id`.
  - `s_ready_in[grant_id]` = `m_ready_in`.
  - On `m_valid_in && m_ready_in && m_last_in`, go to IDLE.
- All non-granted readies are 0. In IDLE every `s_ready_*` and `m_valid_*` is 0.
- Body beats from the grantee are blocked while in HDR. The header always precedes the body.
- Requesters obey AXI rules: valid is not retracted before its handshake. The arbiter does not re-check a request once it is granted.
- Muxes are purely combinational from the registered `grant_id` and state. There is no data storage.
- Reset mid-packet: the asynchronous reset returns the FSM to IDLE and drops all valids/readies immediately. The partial packet is abandoned, and the datapath is reset by the same `rst_n`.

## Timing
- Reset values:
  - state = IDLE
  - `last_grant` = `NUM_SRC-1`, so source 0 has first priority
  - `grant_id` = 0
  - `busy` = 0
  - all `m_valid_*` and `s_ready_*` = 0
- Arbitration latency: request seen in IDLE at cycle t; `m_valid_insert` is high at t+1.
- Header-to-body: header handshake at t; body can transfer from t+1.
- Packet-to-packet: last beat accepted at t; IDLE at t+1; next grant's header is valid at t+2. The one-cycle bubble is mandatory.
- A request arriving while busy waits; it is evaluated in the next IDLE cycle.
- A single active requester is re-granted back-to-back, with the bubble.
- Single-beat packet (`last` on the first beat): BODY lasts exactly one handshake.
- A zero-throughput stall (`m_ready_*` low) holds state and outputs indefinitely.

## Structure
- Package `axis_hdr_pkg` holds the state enum `{IDLE, HDR, BODY}` and the default width constants.
- Sub-module `rr_arbiter` (`NUM_SRC`):
  - inputs: `req`, `last_grant`
  - outputs: one-hot grant, encoded index, `any`
  - purely combinational, double-width rotate-and-priority-encode
- The top holds the FSM, the `grant_id` and `last_grant` registers, and the slice muxes.

## Test plan
- Reset, then source 2 alone requests a 3-beat packet with header `0xAABBCCDD`, `byte_insert_cnt`=1.
  - `m_valid_insert` rises 1 cycle after the request; `grant_id`=2.
  - 3 body beats pass through; FSM returns to IDLE; `busy` falls.
- All 4 sources request continuously with 1-beat packets: grants are 0,1,2,3,0, each 3 cycles apart.
- Grantee 1 asserts `s_valid_in` before its header is accepted: `s_ready_in[1]`=0 until the cycle after the header handshake.
- `m_ready_in` is held low 5 cycles mid-packet: outputs stay stable, no beat is lost or duplicated, and other sources' readies stay 0.
- Source 3 requests while source 0's packet is active: source 3 is granted at IDLE+1 after source 0's last beat.
- `rst_n` is asserted in BODY after 2 of 4 beats:
  - outputs go to their reset values asynchronously
  - after release, source 0 is granted first when all request
